// File: rtl/coproc_mmio_pkg.sv
// Shared definitions for the coprocessor MMIO host: register map, CTRL/STATUS
// bit positions and the host FSM state encoding.
package coproc_mmio_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h01;
    localparam logic [7:0] ADDR_T      = 8'h02;
    localparam logic [7:0] ADDR_DT     = 8'h03;
    localparam logic [7:0] ADDR_G      = 8'h04;

    localparam int CTRL_START    = 0;
    localparam int CTRL_REG_MODE = 1;
    localparam int CTRL_DT_MODE  = 2;
    localparam int CTRL_INIT     = 3;

    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_VALID = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_WR,
        ST_WR_T,
        ST_WR_DT,
        ST_WR_CTRL,
        ST_POLL_RD,
        ST_POLL_CHK,
        ST_RD_G,
        ST_RD_CAP,
        ST_RESP
    } host_state_e;

    function automatic logic [7:0] ctrl_start_word(input logic reg_mode, input logic dt_mode);
        logic [7:0] w;
        w                = '0;
        w[CTRL_START]    = 1'b1;
        w[CTRL_REG_MODE] = reg_mode;
        w[CTRL_DT_MODE]  = dt_mode;
        w[CTRL_INIT]     = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/coproc_mmio_host_cfg_fifo.sv
// Config-write FIFO holding {addr, data} pairs; DEPTH must be a power of two.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cfg_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [15:0] push_data,
    input  logic        pop,
    output logic [15:0] pop_data,
    output logic        full,
    output logic        empty
);
    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << PW) != DEPTH) begin : g_bad_depth
        $error("cfg_fifo DEPTH must be a power of two >= 2");
    end

    logic [15:0] mem_q [DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + (do_push ? (PW+1)'(1) : '0);
        rd_ptr_d = rd_ptr_q + (do_pop ? (PW+1)'(1) : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/coproc_mmio_host.sv
// Bus-master end of the coprocessor MMIO port: drains queued config writes and
// runs inference jobs (write T/dT, start, poll STATUS, read G). Optional poll
// timeout is enabled by defining MMIO_TIMEOUT_EN.
module coproc_mmio_host
    import coproc_mmio_pkg::*;
#(
    parameter int CFG_DEPTH = 8,
    parameter int POLL_MAX  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic       job_valid,
    output logic       job_ready,
    input  logic [7:0] job_T,
    input  logic [7:0] job_dT,
    input  logic       job_reg_mode,
    input  logic       job_dt_mode,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_G,
    output logic       res_timeout,
    output logic       busy,
    output logic       cs,
    output logic       wr,
    output logic       rd,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    input  logic [7:0] rdata
);
    if (POLL_MAX < 1) begin : g_bad_poll
        $error("POLL_MAX must be >= 1");
    end

    host_state_e state_q, state_d;
    logic        cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
    logic [7:0]  addr_q, addr_d, wdata_q, wdata_d;
    logic        res_valid_q, res_valid_d;
    logic [7:0]  res_g_q, res_g_d;
    logic [7:0]  job_t_q, job_t_d, job_dt_q, job_dt_d;
    logic        job_reg_q, job_reg_d, job_dtm_q, job_dtm_d;
    logic        rdy_en_q;

    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [15:0] fifo_head;

`ifdef MMIO_TIMEOUT_EN
    localparam int CW = $clog2(POLL_MAX + 1);
    logic [CW-1:0] poll_cnt_q, poll_cnt_d;
    logic          res_timeout_q, res_timeout_d;
    assign res_timeout = res_timeout_q;
`else
    assign res_timeout = 1'b0;
`endif

    cfg_fifo #(.DEPTH(CFG_DEPTH)) u_cfg_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({cfg_addr, cfg_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cfg_ready = !fifo_full;
    assign fifo_push = cfg_valid && cfg_ready;
    // rdy_en_q keeps job_ready low while reset is asserted
    assign job_ready = rdy_en_q && (state_q == ST_IDLE) && fifo_empty;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign res_valid = res_valid_q;
    assign res_G     = res_g_q;
    assign cs        = cs_q;
    assign wr        = wr_q;
    assign rd        = rd_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;

    always_comb begin
        state_d     = state_q;
        res_valid_d = res_valid_q;
        res_g_d     = res_g_q;
        job_t_d     = job_t_q;
        job_dt_d    = job_dt_q;
        job_reg_d   = job_reg_q;
        job_dtm_d   = job_dtm_q;
        fifo_pop    = 1'b0;
`ifdef MMIO_TIMEOUT_EN
        poll_cnt_d    = poll_cnt_q;
        res_timeout_d = res_timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_CFG_WR;
                end else if (job_valid && job_ready) begin
                    job_t_d   = job_T;
                    job_dt_d  = job_dT;
                    job_reg_d = job_reg_mode;
                    job_dtm_d = job_dt_mode;
                    state_d   = ST_WR_T;
`ifdef MMIO_TIMEOUT_EN
                    res_timeout_d = 1'b0;
`endif
                end
            end
            ST_CFG_WR:  state_d = ST_IDLE;
            ST_WR_T:    state_d = job_dtm_q ? ST_WR_CTRL : ST_WR_DT;
            ST_WR_DT:   state_d = ST_WR_CTRL;
            ST_WR_CTRL: begin
                state_d = ST_POLL_RD;
`ifdef MMIO_TIMEOUT_EN
                poll_cnt_d = '0;
`endif
            end
            ST_POLL_RD: state_d = ST_POLL_CHK;
            ST_POLL_CHK: begin
                if (rdata[STATUS_VALID]) begin
                    state_d = ST_RD_G;
                end else begin
`ifdef MMIO_TIMEOUT_EN
                    if (poll_cnt_q == CW'(POLL_MAX - 1)) begin
                        state_d       = ST_RESP;
                        res_valid_d   = 1'b1;
                        res_g_d       = 8'h00;
                        res_timeout_d = 1'b1;
                    end else begin
                        poll_cnt_d = poll_cnt_q + CW'(1);
                        state_d    = ST_POLL_RD;
                    end
`else
                    state_d = ST_POLL_RD;
`endif
                end
            end
            ST_RD_G:    state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                res_g_d     = rdata;
                res_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase

        // Bus strobes are registered, so they are decoded from the state being entered
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        addr_d  = 8'h00;
        wdata_d = 8'h00;
        case (state_d)
            ST_CFG_WR:  begin cs_d = 1'b1; wr_d = 1'b1; addr_d = fifo_head[15:8]; wdata_d = fifo_head[7:0]; end
            ST_WR_T:    begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_T;  wdata_d = job_t_d; end
            ST_WR_DT:   begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_DT; wdata_d = job_dt_d; end
            ST_WR_CTRL: begin
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = ADDR_CTRL;
                wdata_d = ctrl_start_word(job_reg_d, job_dtm_d);
            end
            ST_POLL_RD: begin cs_d = 1'b1; rd_d = 1'b1; addr_d = ADDR_STATUS; end
            ST_RD_G:    begin cs_d = 1'b1; rd_d = 1'b1; addr_d = ADDR_G; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            res_valid_q <= 1'b0;
            res_g_q     <= 8'h00;
            job_t_q     <= 8'h00;
            job_dt_q    <= 8'h00;
            job_reg_q   <= 1'b0;
            job_dtm_q   <= 1'b0;
            rdy_en_q    <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
            poll_cnt_q    <= '0;
            res_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            res_valid_q <= res_valid_d;
            res_g_q     <= res_g_d;
            job_t_q     <= job_t_d;
            job_dt_q    <= job_dt_d;
            job_reg_q   <= job_reg_d;
            job_dtm_q   <= job_dtm_d;
            rdy_en_q    <= 1'b1;
`ifdef MMIO_TIMEOUT_EN
            poll_cnt_q    <= poll_cnt_d;
            res_timeout_q <= res_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_coproc_mmio_host.sv
// Directed bench for coproc_mmio_host: reset, config drain, jobs with both dT
// modes, result backpressure, reset mid-job and (with MMIO_TIMEOUT_EN) poll timeout.
module tb_coproc_mmio_host;
    import coproc_mmio_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0, job_valid = 1'b0, res_ready = 1'b0;
    logic [7:0] cfg_addr = '0, cfg_data = '0, job_T = '0, job_dT = '0;
    logic       job_reg_mode = 1'b0, job_dt_mode = 1'b0;
    logic [7:0] rdata = 8'hA6;
    logic       cfg_ready, job_ready, res_valid, res_timeout, busy, cs, wr, rd;
    logic [7:0] res_G, addr, wdata;

    int total = 0;
    int bad = 0;
    logic [17:0] bus_log[$];
    int both_cnt = 0;
    int polls = 0;
    int valid_at = 1;
    logic [7:0] g_val = 8'h00;
    int lat;

    always #5 clk = ~clk;

    coproc_mmio_host #(.CFG_DEPTH(8), .POLL_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .job_valid(job_valid), .job_ready(job_ready), .job_T(job_T), .job_dT(job_dT),
        .job_reg_mode(job_reg_mode), .job_dt_mode(job_dt_mode),
        .res_valid(res_valid), .res_ready(res_ready), .res_G(res_G), .res_timeout(res_timeout),
        .busy(busy), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    // Coprocessor responder: STATUS reports valid from the valid_at-th poll after a start
    always @(posedge clk) begin
        if (cs && wr && addr == ADDR_CTRL && wdata[CTRL_START]) polls <= 0;
        if (cs && rd) begin
            if (addr == ADDR_STATUS) begin
                polls <= polls + 1;
                rdata <= (polls + 1 >= valid_at) ? 8'h02 : (8'h01 << STATUS_BUSY);
            end else if (addr == ADDR_G) begin
                rdata <= g_val;
            end else begin
                rdata <= 8'h00;
            end
        end else begin
            rdata <= 8'hA6;
        end
    end

    always @(negedge clk) begin
        if (rst_n && cs) begin
            bus_log.push_back({wr, rd, addr, wdata});
            if (wr && rd) both_cnt++;
        end
    end

    function automatic logic [17:0] bw(input logic [7:0] a, input logic [7:0] d);
        return {2'b10, a, d};
    endfunction
    function automatic logic [17:0] br(input logic [7:0] a);
        return {2'b01, a, 8'h00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reads ignore wdata, so only writes compare the data byte
    task automatic chk_log(input string tag, input int idx, input logic [17:0] exp);
        logic [17:0] obs;
        logic [17:0] mask;
        obs  = (idx < bus_log.size()) ? bus_log[idx] : 18'h3FFFF;
        mask = exp[17] ? 18'h3FFFF : 18'h3FF00;
        chk(tag, 32'(obs & mask), 32'(exp));
    endtask

    task automatic do_job(input logic [7:0] t, input logic [7:0] dt, input logic rm,
                          input logic dm, output int l);
        int k;
        k = 0;
        while (!job_ready && k < 50) begin @(negedge clk); k++; end
        chk("job_ready_wait", job_ready, 1);
        job_valid = 1'b1; job_T = t; job_dT = dt; job_reg_mode = rm; job_dt_mode = dm;
        @(negedge clk);
        job_valid = 1'b0;
        l = 1;
        while (!res_valid && l < 200) begin @(negedge clk); l++; end
    endtask

    task automatic finish_resp();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_strobes", {cs, wr, rd}, 0);
        chk("rst_addr_wdata", {addr, wdata}, 0);
        chk("rst_result", {res_valid, res_G, res_timeout}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_job_ready", job_ready, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Config drain
        cfg_valid = 1'b1; cfg_addr = 8'h10; cfg_data = 8'h05;
        chk("cfg_ready_1", cfg_ready, 1);
        @(negedge clk);
        cfg_addr = 8'h11; cfg_data = 8'h20;
        chk("cfg_ready_2", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("cfg_ready_3", cfg_ready, 1);
        repeat (8) @(negedge clk);
        chk("cfg_log_len", bus_log.size(), 2);
        chk_log("cfg_wr0", 0, bw(8'h10, 8'h05));
        chk_log("cfg_wr1", 1, bw(8'h11, 8'h20));
        chk("cfg_idle_busy", busy, 0);

        // Job 1: dt_mode=0, reg_mode=1, valid on third poll
        bus_log.delete();
        valid_at = 3; g_val = 8'h3C;
        do_job(8'h1E, 8'hF6, 1'b1, 1'b0, lat);
        chk("job1_latency", lat, 12);
        chk("job1_res_G", res_G, 8'h3C);
        chk("job1_timeout", res_timeout, 0);
        chk("job1_log_len", bus_log.size(), 7);
        chk_log("job1_wr_T", 0, bw(ADDR_T, 8'h1E));
        chk_log("job1_wr_DT", 1, bw(ADDR_DT, 8'hF6));
        chk_log("job1_wr_CTRL", 2, bw(ADDR_CTRL, 8'h03));
        chk_log("job1_poll0", 3, br(ADDR_STATUS));
        chk_log("job1_poll1", 4, br(ADDR_STATUS));
        chk_log("job1_poll2", 5, br(ADDR_STATUS));
        chk_log("job1_rd_G", 6, br(ADDR_G));

        // Backpressure with a config queued during RESP
        bus_log.delete();
        cfg_valid = 1'b1; cfg_addr = 8'h20; cfg_data = 8'h7A;
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_G", res_G, 8'h3C);
            chk("bp_job_ready", job_ready, 0);
            @(negedge clk);
        end
        chk("bp_no_bus", bus_log.size(), 0);
        chk("bp_busy", busy, 1);
        finish_resp();
        chk("bp_cfg_after_hs_0", bus_log.size(), 0);
        repeat (4) @(negedge clk);
        chk("bp_cfg_len", bus_log.size(), 1);
        chk_log("bp_cfg_wr", 0, bw(8'h20, 8'h7A));

        // Job 2: dt_mode=1 skips the DT write
        bus_log.delete();
        valid_at = 1; g_val = 8'h11;
        do_job(8'hEC, 8'h55, 1'b0, 1'b1, lat);
        chk("job2_latency", lat, 7);
        chk("job2_res_G", res_G, 8'h11);
        chk("job2_timeout", res_timeout, 0);
        chk("job2_log_len", bus_log.size(), 4);
        chk_log("job2_wr_T", 0, bw(ADDR_T, 8'hEC));
        chk_log("job2_wr_CTRL", 1, bw(ADDR_CTRL, 8'h05));
        chk_log("job2_poll", 2, br(ADDR_STATUS));
        chk_log("job2_rd_G", 3, br(ADDR_G));
        finish_resp();

`ifdef MMIO_TIMEOUT_EN
        // STATUS never valid: four polls then timeout result
        bus_log.delete();
        valid_at = 1000;
        do_job(8'h05, 8'h00, 1'b0, 1'b1, lat);
        chk("to_latency", lat, 11);
        chk("to_res_valid", res_valid, 1);
        chk("to_res_G", res_G, 8'h00);
        chk("to_timeout", res_timeout, 1);
        chk("to_log_len", bus_log.size(), 6);
        for (int i = 2; i < 6; i++) chk_log("to_poll", i, br(ADDR_STATUS));
        finish_resp();
        valid_at = 1;
`endif

        // Reset asserted during WR_CTRL with a config queued
        bus_log.delete();
        chk("rst2_job_ready", job_ready, 1);
        job_valid = 1'b1; job_T = 8'h40; job_dT = 8'h02; job_reg_mode = 1'b0; job_dt_mode = 1'b0;
        @(negedge clk);
        job_valid = 1'b0;
        cfg_valid = 1'b1; cfg_addr = 8'h30; cfg_data = 8'h01;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("rst2_in_wr_ctrl", {cs, wr, rd, addr}, {3'b110, ADDR_CTRL});
        #1 rst_n = 1'b0;
        #1;
        chk("rst2_strobes", {cs, wr, rd}, 0);
        chk("rst2_res_valid", res_valid, 0);
        chk("rst2_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_cfg_ready", cfg_ready, 1);
        chk("rst2_busy_after", busy, 0);
        chk("rst2_job_ready_after", job_ready, 1);
        repeat (3) @(negedge clk);
        chk("rst2_log_len", bus_log.size(), 3);
        chk_log("rst2_wr_CTRL", 2, bw(ADDR_CTRL, 8'h01));

        chk("wr_rd_exclusive", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
